bcd_hex_display: RTL and testbench



---
 rtl/bcd_hex_display.sv | 197 +++++++++++++++++++
 tb/tb_bcd_hex_display.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_hex_display.sv
// -----------------------------------------------------------------------------
// bcd_hex_display
//
// Takes an unsigned binary value from the CPU I/O output register and shows it
// in decimal on the eight DE2-115 seven-segment displays. The conversion is an
// iterative double-dabble (shift-add-3) that handles one input bit per clock.
// The resulting digits are latched together, so the displays never show a
// partially converted value.
//
// Handshake: a value is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only while the block is idle. A
// value presented while the block is busy is not taken and not queued; the
// upstream keeps in_valid asserted until the transfer happens.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   in_valid  a new value is present on in_data
//   in_data   unsigned binary value to display (WIDTH bits)
//   in_ready  block idle and able to accept a value
//   done      one-cycle pulse when new digits reach the HEX outputs
//   overflow  decimal value needs more than 8 digits; held with the digits
//   HEX0..7   active-low segments, bit0 = a ... bit6 = g; HEX0 = ones digit
// -----------------------------------------------------------------------------
module bcd_hex_display #(
    parameter int WIDTH    = 32,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             done,
    output logic             overflow,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX6,
    output logic [6:0]       HEX7
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] bin_q;      // binary bits still to be shifted in
    logic [39:0]      bcd_q;      // ten BCD digits being accumulated
    logic [CW-1:0]    cnt_q;      // shifts remaining
    logic [3:0]       dig_q [8];  // displayed digits, 0 = ones

    logic [39:0]      bcd_adj;
    logic [39:0]      bcd_next;
    logic [WIDTH-1:0] bin_next;
    logic [7:0]       keep;       // 1 = digit is shown, 0 = blanked
    logic [6:0]       hex [8];

    // Active-low segment pattern for one digit; non-BCD codes are blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // cnt_q == 1 means this cycle performs the final shift.
                if (cnt_q == CW'(1)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------- double-dabble step
    // Any digit >= 5 would become >= 10 after doubling, so it is pre-biased
    // by 3 to make the carry land in the next digit after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_next, bin_next} = {bcd_adj, bin_q} << 1;
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= 4'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q <= in_data;
                        bcd_q <= '0;
                        cnt_q <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_next;
                    bin_q <= bin_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                LATCH: begin
                    for (int i = 0; i < 8; i++) begin
                        dig_q[i] <= bcd_q[4*i +: 4];
                    end
                    overflow <= (bcd_q[39:32] != 8'd0);
                    done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------- leading-zero blank
    // Digit k (k >= 1) is shown when it or any more significant displayed
    // digit is nonzero; the ones digit is always shown.
    always_comb begin
        keep    = 8'hFF;
        keep[7] = (dig_q[7] != 4'd0);
        for (int k = 6; k >= 1; k--) begin
            keep[k] = keep[k+1] | (dig_q[k] != 4'd0);
        end
        keep[0] = 1'b1;
        if (!BLANK_LZ) begin
            keep = 8'hFF;
        end
        for (int k = 0; k < 8; k++) begin
            hex[k] = keep[k] ? seg7(dig_q[k]) : 7'h7F;
        end
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];
    assign HEX6 = hex[6];
    assign HEX7 = hex[7];

endmodule

// File: tb/tb_bcd_hex_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_hex_display
//
// Directed self-checking bench for bcd_hex_display (WIDTH=32, BLANK_LZ=1).
// Expected segment patterns are written out by hand as {HEX7, ..., HEX0}.
// -----------------------------------------------------------------------------
module tb_bcd_hex_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        done;
    logic        overflow;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int checks = 0;
    int errors = 0;

    localparam logic [55:0] RESET_HEX = {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                                         7'h7F, 7'h7F, 7'h7F, 7'h40};

    bcd_hex_display #(
        .WIDTH    (32),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
        .overflow (overflow),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .HEX6     (HEX6),
        .HEX7     (HEX7)
    );

    // ------------------------------------------------- clock
    always #5 clk = ~clk;

    function automatic logic [55:0] hex_all();
        return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // ------------------------------------------------- drivers
    // One-cycle transfer; caller guarantees the block is idle.
    task automatic start(input logic [31:0] val);
        in_valid = 1'b1;
        in_data  = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the transfer edge to the edge that raises done; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // ------------------------------------------------- tests
    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got done=%b ovf=%b want 0 0", done, overflow);
        end
        checks++;
        if (hex_all() !== RESET_HEX) begin
            errors++;
            $display("FAIL reset_hex got %h want %h", hex_all(), RESET_HEX);
        end
    endtask

    task automatic test_values();
        logic [31:0] vals [7];
        logic [55:0] exp_hex [7];
        logic        exp_ovf [7];
        int          lat;
        vals[0] = 32'd1234;
        exp_hex[0] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
        exp_ovf[0] = 1'b0;
        vals[1] = 32'h05F5E0FF;  // 99999999
        exp_hex[1] = {8{7'h10}};
        exp_ovf[1] = 1'b0;
        vals[2] = 32'h05F5E100;  // 100000000
        exp_hex[2] = RESET_HEX;
        exp_ovf[2] = 1'b1;
        vals[3] = 32'hFFFFFFFF;  // 4294967295 -> 94967295
        exp_hex[3] = {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12};
        exp_ovf[3] = 1'b1;
        vals[4] = 32'd0;
        exp_hex[4] = RESET_HEX;
        exp_ovf[4] = 1'b0;
        vals[5] = 32'd1000005;   // inner zeros stay visible
        exp_hex[5] = {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};
        exp_ovf[5] = 1'b0;
        vals[6] = 32'd10;
        exp_hex[6] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40};
        exp_ovf[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            start(vals[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_ready[%0d] got %b want 0", i, in_ready);
            end
            wait_done(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL latency[%0d] got %0d want 33", i, lat);
            end
            checks++;
            if (hex_all() !== exp_hex[i]) begin
                errors++;
                $display("FAIL hex[%0d] val=%0d got %h want %h", i, vals[i], hex_all(), exp_hex[i]);
            end
            checks++;
            if (overflow !== exp_ovf[i]) begin
                errors++;
                $display("FAIL overflow[%0d] got %b want %b", i, overflow, exp_ovf[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_done[%0d] got done=%b rdy=%b want 0 1", i, done, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(posedge clk);
        #1;
        in_data = 32'd8;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (d1 > 0 && k == d1 + 1) begin
                in_valid = 1'b0;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    checks++;
                    if (hex_all() !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}) begin
                        errors++;
                        $display("FAIL b2b_first_hex got %h want 7 blanks + 12", hex_all());
                    end
                end else begin
                    d2 = k;
                    break;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (d1 !== 33) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d want 33", d1);
        end
        checks++;
        if (d2 - d1 !== 34) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 34", d2 - d1);
        end
        checks++;
        if (hex_all() !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}) begin
            errors++;
            $display("FAIL b2b_second_hex got %h want 7 blanks + 00", hex_all());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignored();
        int lat;
        int extra = 0;
        start(32'd42);
        repeat (9) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'd5678;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL busy_latency got %0d want 21 after ignored request", lat);
        end
        checks++;
        if (hex_all() !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}) begin
            errors++;
            $display("FAIL busy_hex got %h want 42 pattern", hex_all());
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_queued got %0d extra done pulses want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray = 0;
        start(32'hFFFFFFFF);
        wait_done(lat);
        @(posedge clk);
        #1;
        start(32'd7);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        checks++;
        if (hex_all() !== {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}) begin
            errors++;
            $display("FAIL hold_during_conv got %h want previous display", hex_all());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || overflow !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flags got rdy=%b ovf=%b done=%b want 1 0 0", in_ready, overflow, done);
        end
        checks++;
        if (hex_all() !== RESET_HEX) begin
            errors++;
            $display("FAIL mid_reset_hex got %h want %h", hex_all(), RESET_HEX);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL mid_reset_done got %0d pulses want 0", stray);
        end
    endtask

    task automatic test_reset_priority();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd9;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_priority got rdy=%b want 1", in_ready);
        end
    endtask

    // ------------------------------------------------- sequence + report
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_values();
        test_back_to_back();
        test_busy_ignored();
        test_reset_mid();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
